multi_expr_chk: RTL and testbench

Parametrised multi-channel runtime assertion checker: watches NCH single-bit expressions and reports two error types. A gap error is raised when an enabled expression stays low for MAXGAP consecutive cycles; an unknown error is raised when an enabled expression carries X/Z. The block keeps a saturating error count and a sticky first-failure record. It instantiates beside any block under test in regression benches, generalising the single-expression, every-cycle checker to multiple channels, a gap tolerance and a readable error log.

---
 rtl/multi_expr_chk.sv | 109 ++++++++++
 tb/tb_multi_expr_chk.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/multi_expr_chk.sv
// multi_expr_chk: NCH-channel gap/unknown assertion checker; MULTI_EXPR_CHK_XCHECK_EN enables X/Z detection
module multi_expr_chk #(
   parameter int NCH    = 4,
   parameter int MAXGAP = 1,
   parameter int ERRW   = 16,
   parameter int CYCW   = 32,
   localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int GW    = ($clog2(MAXGAP + 1) > 1) ? $clog2(MAXGAP + 1) : 1
) (
   input  logic            clk,
   input  logic            rst_l,
   input  logic [NCH-1:0]  en,
   input  logic [NCH-1:0]  expr,
   input  logic            clr,
   output logic [NCH-1:0]  err_pulse,
   output logic [ERRW-1:0] err_count,
   output logic            first_valid,
   output logic [CHW-1:0]  first_chan,
   output logic [1:0]      first_kind,
   output logic [CYCW-1:0] first_cycle
);
   localparam int PW = 6;
   localparam int SW = ERRW + PW;
   logic [CYCW-1:0] cyc;
   logic [GW-1:0]   gap     [NCH];
   logic [GW-1:0]   gap_nxt [NCH];
   logic [NCH-1:0]  gap_err, unk_err, err;
   logic [PW-1:0]   pop;
   logic [SW-1:0]   sum;
   logic [ERRW-1:0] cnt_nxt;
   logic [CHW-1:0]  fc_nxt;
   logic [1:0]      fk_nxt;
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         gap_err[i] = 1'b0;
         unk_err[i] = 1'b0;
         gap_nxt[i] = '0;
         if (en[i]) begin
`ifdef MULTI_EXPR_CHK_XCHECK_EN
            if ((expr[i] ^ expr[i]) !== 1'b0) begin
               unk_err[i] = 1'b1;
               gap_nxt[i] = gap[i];
            end else
`endif
            if (!expr[i]) begin
               if (gap[i] == GW'(MAXGAP - 1)) gap_err[i] = 1'b1;
               else gap_nxt[i] = gap[i] + 1'b1;
            end
         end
      end
   end
   assign err = gap_err | unk_err;
   // saturating add in a wider sum so the popcount can never wrap the total
   always_comb begin
      pop = '0;
      for (int i = 0; i < NCH; i++) pop = pop + PW'(err[i]);
      sum = SW'(err_count) + SW'(pop);
      cnt_nxt = (sum > SW'({ERRW{1'b1}})) ? {ERRW{1'b1}} : sum[ERRW-1:0];
   end
   always_comb begin
      fc_nxt = '0;
      fk_nxt = 2'd0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (err[i]) begin
            fc_nxt = CHW'(i);
            fk_nxt = unk_err[i] ? 2'd2 : 2'd1;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         cyc         <= '0;
         err_pulse   <= '0;
         err_count   <= '0;
         first_valid <= 1'b0;
         first_chan  <= '0;
         first_kind  <= 2'd0;
         first_cycle <= '0;
         for (int i = 0; i < NCH; i++) gap[i] <= '0;
      end else begin
         cyc <= cyc + 1'b1;
         if (clr) begin
            err_pulse   <= '0;
            err_count   <= '0;
            first_valid <= 1'b0;
            first_chan  <= '0;
            first_kind  <= 2'd0;
            first_cycle <= '0;
            for (int i = 0; i < NCH; i++) gap[i] <= '0;
         end else begin
            err_pulse <= err;
            err_count <= cnt_nxt;
            for (int i = 0; i < NCH; i++) gap[i] <= gap_nxt[i];
            if (!first_valid && |err) begin
               first_valid <= 1'b1;
               first_chan  <= fc_nxt;
               first_kind  <= fk_nxt;
               first_cycle <= cyc;
            end
         end
      end
   end
`ifdef MULTI_EXPR_CHK_XCHECK_EN
   always @(posedge clk) begin
      for (int i = 0; i < NCH; i++)
         if (rst_l && !clr && unk_err[i]) $display("multi_expr_chk: unknown on channel %0d at cycle %0d", i, cyc);
   end
`endif
endmodule

// File: tb/tb_multi_expr_chk.sv
// tb_multi_expr_chk: directed checks of two checker instances (MAXGAP=3/ERRW=16 and MAXGAP=1/ERRW=4)
module tb_multi_expr_chk;
   logic        clk = 1'b0;
   logic        rst_l = 1'b0;
   logic [3:0]  en = 4'h0;
   logic [3:0]  expr = 4'hF;
   logic        clr = 1'b0;
   logic [3:0]  pa, pb;
   logic [15:0] ca;
   logic [3:0]  cb;
   logic        fva, fvb;
   logic [1:0]  fca, fcb, fka, fkb;
   logic [31:0] fya, fyb;
   int          n_cmp = 0;
   int          n_err = 0;
   int          edge_n = 0;
   int          s3, s1;
   always #5 clk = ~clk;
   multi_expr_chk #(.NCH(4), .MAXGAP(3), .ERRW(16), .CYCW(32)) u_a (
      .clk(clk), .rst_l(rst_l), .en(en), .expr(expr), .clr(clr),
      .err_pulse(pa), .err_count(ca), .first_valid(fva), .first_chan(fca),
      .first_kind(fka), .first_cycle(fya));
   multi_expr_chk #(.NCH(4), .MAXGAP(1), .ERRW(4), .CYCW(32)) u_b (
      .clk(clk), .rst_l(rst_l), .en(en), .expr(expr), .clr(clr),
      .err_pulse(pb), .err_count(cb), .first_valid(fvb), .first_chan(fcb),
      .first_kind(fkb), .first_cycle(fyb));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
      edge_n++;
   endtask
   initial begin
      repeat (3) @(posedge clk);
      #2;
      chk("rst_pa", 32'(pa), 0);
      chk("rst_ca", 32'(ca), 0);
      chk("rst_fva", 32'(fva), 0);
      chk("rst_fka", 32'(fka), 0);
      chk("rst_fya", fya, 0);
      chk("rst_cb", 32'(cb), 0);
      rst_l = 1'b1;
      en = 4'hF;
      expr = 4'hF;
      for (int k = 0; k < 20; k++) begin
         step();
         chk("hi_pa", 32'(pa), 0);
         chk("hi_pb", 32'(pb), 0);
      end
      chk("hi_ca", 32'(ca), 0);
      chk("hi_cb", 32'(cb), 0);
      chk("hi_fva", 32'(fva), 0);
      chk("hi_fvb", 32'(fvb), 0);
      expr = 4'b1011;
      s3 = 0;
      s1 = edge_n;
      for (int k = 1; k <= 7; k++) begin
         if (k == 3) s3 = edge_n;
         step();
         chk("gap_pa", 32'(pa), (k == 3 || k == 6) ? 32'h4 : 32'h0);
         chk("gap_pb", 32'(pb), 32'h4);
      end
      chk("gap_ca", 32'(ca), 2);
      chk("gap_fva", 32'(fva), 1);
      chk("gap_fca", 32'(fca), 2);
      chk("gap_fka", 32'(fka), 1);
      chk("gap_fya", fya, 32'(s3));
      chk("gap_cb", 32'(cb), 7);
      chk("gap_fyb", fyb, 32'(s1));
      expr = 4'hF;
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_ca", 32'(ca), 0);
      chk("clr_fva", 32'(fva), 0);
      chk("clr_fka", 32'(fka), 0);
      expr = 4'b0101;
      step();
      chk("dual_pb", 32'(pb), 32'hA);
      chk("dual_cb", 32'(cb), 2);
      chk("dual_fcb", 32'(fcb), 1);
      step();
      chk("dual_pa2", 32'(pa), 0);
      step();
      chk("dual_pa", 32'(pa), 32'hA);
      chk("dual_ca", 32'(ca), 2);
      chk("dual_fca", 32'(fca), 1);
      chk("dual_fka", 32'(fka), 1);
      chk("dual_cb3", 32'(cb), 6);
      expr = 4'hF;
      clr = 1'b1;
      step();
      clr = 1'b0;
      expr = 4'b1110;
      for (int k = 1; k <= 20; k++) begin
         step();
         chk("sat_cb", 32'(cb), (k > 15) ? 32'd15 : 32'(k));
      end
      expr = 4'hF;
      clr = 1'b1;
      step();
      clr = 1'b0;
      expr = 4'b1110;
      step();
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clre_pa", 32'(pa), 0);
      chk("clre_ca", 32'(ca), 0);
      chk("clre_fva", 32'(fva), 0);
      chk("clre_cb", 32'(cb), 0);
      step();
      step();
      chk("pre_dis_pa", 32'(pa), 0);
      en = 4'b1110;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("dis_pa", 32'(pa), 0);
         chk("dis_pb", 32'(pb), 0);
      end
      chk("dis_ca", 32'(ca), 0);
      en = 4'hF;
      step();
      chk("ren_pa1", 32'(pa), 0);
      step();
      chk("ren_pa2", 32'(pa), 0);
      step();
      chk("ren_pa3", 32'(pa), 1);
      chk("ren_ca", 32'(ca), 1);
      chk("ren_fca", 32'(fca), 0);
      expr = 4'hF;
      clr = 1'b1;
      step();
      clr = 1'b0;
      expr = 4'bx111;
      step();
      expr = 4'hF;
`ifdef MULTI_EXPR_CHK_XCHECK_EN
      chk("x_pa", 32'(pa), 32'h8);
      chk("x_fka", 32'(fka), 2);
      chk("x_fca", 32'(fca), 3);
      step();
      chk("x_pa_once", 32'(pa), 0);
      chk("x_ca", 32'(ca), 1);
`else
      chk("x_pa", 32'(pa), 0);
      chk("x_fva", 32'(fva), 0);
      step();
      chk("x_pa_once", 32'(pa), 0);
      chk("x_ca", 32'(ca), 0);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
